// File: rtl/hart_pkg.sv
// Shared constants and types for the rv6 hart hazard/forwarding slice.
package hart_pkg;

  // Register x0 is hardwired to zero, so it never creates a dependency.
  localparam int X0     = 0;

  // Back-end stage indices. A lower index is a younger instruction.
  localparam int ST_EX  = 0;
  localparam int ST_MEM = 1;
  localparam int ST_WB  = 2;

  // Width of a stage-index select. Never returns less than one bit.
  function automatic int sel_w(input int nstg);
    return (nstg > 1) ? $clog2(nstg) : 1;
  endfunction

  // Per-operand result from the priority matcher.
  typedef struct packed {
    logic matched;  // some live back-end stage writes this source
    logic fwd_ok;   // the winning producer can feed EX through forwarding
    logic hz;       // a producer exists but cannot forward: ID must hold
  } match_rsp_t;

endpackage

// File: rtl/hazard_fwd_unit_match.sv
// Per-operand priority matcher. It compares one ID source register against
// every back-end destination. The youngest live writer wins.
module hfu_match
  import hart_pkg::*;
#(
  parameter int NSTG = 3,
  parameter int RAW  = 5,
  parameter int SELW = sel_w(NSTG)
) (
  input  logic [RAW-1:0]            rs,
  input  logic                      rs_use,
  input  logic                      early,
  input  logic [NSTG-1:0][RAW-1:0]  bk_rd,
  input  logic [NSTG-1:0]           bk_wr,
  input  logic [NSTG-1:0]           bk_ld,
  input  logic [NSTG-1:0]           bub,
  output match_rsp_t                rsp,
  output logic [SELW-1:0]           win
);

  logic [NSTG-1:0] hit;
  logic            ld_win;

  // A stage can source this operand only if it holds a real instruction
  // that writes a non-x0 register equal to the source.
  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_hit
      assign hit[gi] = rs_use & bk_wr[gi] & ~bub[gi] &
                       (bk_rd[gi] == rs) & (bk_rd[gi] != RAW'(X0));
    end
  endgenerate

  // Scan from oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    rsp.matched = 1'b0;
    win         = '0;
    ld_win      = 1'b0;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        rsp.matched = 1'b1;
        win         = SELW'(i);
        ld_win      = bk_ld[i];
      end
    end
    rsp.fwd_ok = rsp.matched & ~early & ~ld_win;
    rsp.hz     = rsp.matched & ~rsp.fwd_ok;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit. It sits beside ID, injects bubbles on
// unresolvable RAW hazards, registers the EX forwarding selects and counts
// data-hazard stall cycles.
module hazard_fwd_unit
  import hart_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int NSTG = 3,
  parameter int RAW  = 5,
  parameter int SELW = sel_w(NSTG),
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ext_stall,
  input  logic                 amo_req,
  input  logic                 amo_ack,
  input  logic [NSRC*RAW-1:0]  id_rs,
  input  logic [NSRC-1:0]      id_rs_use,
  input  logic                 id_early,
  input  logic [NSTG*RAW-1:0]  bk_rd,
  input  logic [NSTG-1:0]      bk_wr,
  input  logic [NSTG-1:0]      bk_ld,
  output logic                 stall_if,
  output logic                 stall_fe,
  output logic [NSTG-1:0]      stall_be,
  output logic [NSTG-1:0]      bub,
  output logic [NSRC-1:0]      fw_en,
  output logic [NSRC*SELW-1:0] fw_sel,
  output logic [CNTW-1:0]      stall_cnt
);

  logic [NSRC-1:0][RAW-1:0]  rs_a;
  logic [NSTG-1:0][RAW-1:0]  rd_a;
  match_rsp_t [NSRC-1:0]     rsp;
  logic [NSRC-1:0][SELW-1:0] win;
  logic [NSRC-1:0]           hz;
  logic [NSRC-1:0]           fwd_ok;
  logic                      frz;
  logic                      dh;

  logic [NSTG-1:0]           bub_q;
  logic [NSRC-1:0]           fw_en_q;
  logic [NSRC-1:0][SELW-1:0] fw_sel_q;
  logic [CNTW-1:0]           cnt_q;

  assign rs_a = id_rs;
  assign rd_a = bk_rd;

  hfu_match #(.NSTG(NSTG), .RAW(RAW), .SELW(SELW)) u_match [NSRC-1:0] (
    .rs     (rs_a),
    .rs_use (id_rs_use),
    .early  ({NSRC{id_early}}),
    .bk_rd  ({NSRC{rd_a}}),
    .bk_wr  ({NSRC{bk_wr}}),
    .bk_ld  ({NSRC{bk_ld}}),
    .bub    ({NSRC{bub_q}}),
    .rsp    (rsp),
    .win    (win)
  );

  // Split the matcher responses into per-operand hazard and forward vectors.
  always_comb begin
    hz     = '0;
    fwd_ok = '0;
    for (int j = 0; j < NSRC; j++) begin
      hz[j]     = rsp[j].hz;
      fwd_ok[j] = rsp[j].fwd_ok;
    end
  end

  // Reset counts as a freeze, so the front end is held during the reset cycle.
  assign frz      = ~rst_n | ext_stall | (amo_req & ~amo_ack);
  assign dh       = |hz;
  assign stall_be = {NSTG{frz}};
  assign stall_fe = frz | dh;
  assign stall_if = frz | dh | amo_req;

  assign bub       = bub_q;
  assign fw_en     = fw_en_q;
  assign fw_sel    = fw_sel_q;
  assign stall_cnt = cnt_q;

  // Bubble shift register, forwarding registers and stall counter. All of
  // them hold while the pipe is frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bub_q    <= '1;
      fw_en_q  <= '0;
      fw_sel_q <= '0;
      cnt_q    <= '0;
    end else if (!frz) begin
      bub_q <= NSTG'({bub_q, dh});
      if (dh) begin
        // ID holds and a bubble enters EX. The bubble carries no operands.
        fw_en_q <= '0;
        cnt_q   <= cnt_q + CNTW'(1);
      end else begin
        fw_en_q  <= fwd_ok;
        fw_sel_q <= win;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with the default configuration (2 sources, 3 stages).
module tb_hazard_fwd_unit;

  localparam int NSRC = 2;
  localparam int NSTG = 3;
  localparam int RAW  = 5;
  localparam int SELW = 2;
  localparam int CNTW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ext_stall, amo_req, amo_ack, id_early;
  logic [NSRC*RAW-1:0]  id_rs;
  logic [NSRC-1:0]      id_rs_use;
  logic [NSTG*RAW-1:0]  bk_rd;
  logic [NSTG-1:0]      bk_wr, bk_ld;
  logic                 stall_if, stall_fe;
  logic [NSTG-1:0]      stall_be, bub;
  logic [NSRC-1:0]      fw_en;
  logic [NSRC*SELW-1:0] fw_sel;
  logic [CNTW-1:0]      stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_fwd_unit #(.NSRC(NSRC), .NSTG(NSTG), .RAW(RAW), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_stall (ext_stall),
    .amo_req   (amo_req),
    .amo_ack   (amo_ack),
    .id_rs     (id_rs),
    .id_rs_use (id_rs_use),
    .id_early  (id_early),
    .bk_rd     (bk_rd),
    .bk_wr     (bk_wr),
    .bk_ld     (bk_ld),
    .stall_if  (stall_if),
    .stall_fe  (stall_fe),
    .stall_be  (stall_be),
    .bub       (bub),
    .fw_en     (fw_en),
    .fw_sel    (fw_sel),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ext_stall = 0; amo_req = 0; amo_ack = 0; id_early = 0;
    id_rs = '0; id_rs_use = '0; bk_rd = '0; bk_wr = '0; bk_ld = '0;
  endtask

  task automatic set_rs(input int j, input int r);
    id_rs[j*RAW +: RAW] = RAW'(r);
  endtask

  task automatic set_rd(input int i, input int r);
    bk_rd[i*RAW +: RAW] = RAW'(r);
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    chk("rst_bub",    bub, 3'b111);
    chk("rst_fw_en",  fw_en, 2'b00);
    chk("rst_fw_sel", fw_sel, 4'b0000);
    chk("rst_cnt",    stall_cnt, 0);
    chk("rst_fe",     stall_fe, 1);
    chk("rst_be",     stall_be, 3'b111);

    // Release reset. The bubbles drain one stage per cycle.
    rst_n = 1; #1;
    chk("rel_fe", stall_fe, 0);
    tick(); chk("drain1", bub, 3'b110);
    tick(); chk("drain2", bub, 3'b100);
    tick(); chk("drain3", bub, 3'b000);

    // ALU RAW: EX writes x5 and rs1 reads x5, so the value forwards from EX.
    set_rd(0, 5); bk_wr = 3'b001; set_rs(0, 5); id_rs_use = 2'b01; #1;
    chk("alu_fe", stall_fe, 0);
    tick();
    chk("alu_fw_en",  fw_en, 2'b01);
    chk("alu_fw_sel", fw_sel, 4'b0000);

    // Load-use: one bubble, then the load forwards from MEM.
    clr(); set_rd(0, 7); bk_wr = 3'b001; bk_ld = 3'b001; set_rs(1, 7); id_rs_use = 2'b10; #1;
    chk("ld_fe", stall_fe, 1);
    chk("ld_if", stall_if, 1);
    tick();
    chk("ld_bub",   bub, 3'b001);
    chk("ld_cnt",   stall_cnt, 1);
    chk("ld_fw_en", fw_en, 2'b00);
    clr(); set_rd(1, 7); bk_wr = 3'b010; set_rs(1, 7); id_rs_use = 2'b10; #1;
    chk("ld2_fe", stall_fe, 0);
    tick();
    chk("ld2_fw_en",  fw_en, 2'b10);
    chk("ld2_fw_sel", fw_sel, 4'b0100);
    chk("ld2_bub",    bub, 3'b010);
    chk("ld2_cnt",    stall_cnt, 1);

    clr(); tick(); tick();
    chk("flush1", bub, 3'b000);

    // Early use: a branch on x3 while the producer walks EX, MEM and WB.
    id_early = 1; set_rs(0, 3); id_rs_use = 2'b01;
    set_rd(0, 3); bk_wr = 3'b001; #1;
    chk("br_fe0", stall_fe, 1);
    tick(); chk("br_bub0", bub, 3'b001);
    set_rd(0, 0); set_rd(1, 3); bk_wr = 3'b010; #1;
    chk("br_fe1", stall_fe, 1);
    tick(); chk("br_bub1", bub, 3'b011);
    set_rd(1, 0); set_rd(2, 3); bk_wr = 3'b100; #1;
    chk("br_fe2", stall_fe, 1);
    tick(); chk("br_bub2", bub, 3'b111);
    chk("br_cnt3", stall_cnt, 4);
    bk_wr = 3'b000; #1;
    chk("br_fe3", stall_fe, 0);
    tick();
    chk("br_bub3",  bub, 3'b110);
    chk("br_fw_en", fw_en, 2'b00);
    chk("br_cnt",   stall_cnt, 4);

    clr(); tick(); tick();
    chk("flush2", bub, 3'b000);

    // Priority: WB alone forwards with select 2. With EX also writing x4, EX wins.
    set_rd(2, 4); bk_wr = 3'b100; set_rs(0, 4); id_rs_use = 2'b01;
    tick();
    chk("wb_fw_en",  fw_en, 2'b01);
    chk("wb_fw_sel", fw_sel, 4'b0010);
    set_rd(0, 4); bk_wr = 3'b101;
    tick();
    chk("pri_fw_en",  fw_en, 2'b01);
    chk("pri_fw_sel", fw_sel, 4'b0000);

    // Freeze: a load-use hazard under ext_stall changes no state.
    clr(); set_rd(0, 9); bk_wr = 3'b001; bk_ld = 3'b001; set_rs(1, 9); id_rs_use = 2'b10;
    ext_stall = 1; #1;
    chk("frz_fe", stall_fe, 1);
    chk("frz_be", stall_be, 3'b111);
    chk("frz_if", stall_if, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("frz_bub",   bub, 3'b000);
    chk("frz_cnt",   stall_cnt, 4);
    chk("frz_fw_en", fw_en, 2'b01);
    ext_stall = 0; #1;
    chk("unfrz_be", stall_be, 3'b000);
    tick();
    chk("unfrz_bub",   bub, 3'b001);
    chk("unfrz_cnt",   stall_cnt, 5);
    chk("unfrz_fw_en", fw_en, 2'b00);

    clr(); tick(); tick(); tick();
    chk("flush3", bub, 3'b000);

    // x0: a pending load to x0 never stalls and never forwards.
    set_rd(0, 0); bk_wr = 3'b001; bk_ld = 3'b001; set_rs(0, 0); id_rs_use = 2'b01; #1;
    chk("x0_fe", stall_fe, 0);
    tick();
    chk("x0_fw_en", fw_en, 2'b00);
    chk("x0_cnt",   stall_cnt, 5);

    // Atomic: the whole pipe stalls until the ack arrives. Fetch stays held while amo_req is high.
    clr(); amo_req = 1; #1;
    chk("amo_if", stall_if, 1);
    chk("amo_be", stall_be, 3'b111);
    chk("amo_fe", stall_fe, 1);
    tick();
    chk("amo_bub", bub, 3'b000);
    amo_ack = 1; #1;
    chk("ack_be", stall_be, 3'b000);
    chk("ack_if", stall_if, 1);
    chk("ack_fe", stall_fe, 0);

    // Reset in the middle of a hazard drops it and restores the reset state.
    clr(); set_rd(0, 7); bk_wr = 3'b001; bk_ld = 3'b001; set_rs(0, 7); id_rs_use = 2'b01; #1;
    chk("mr_dh", stall_fe, 1);
    rst_n = 0;
    tick();
    chk("mr_bub",   bub, 3'b111);
    chk("mr_cnt",   stall_cnt, 0);
    chk("mr_fw_en", fw_en, 2'b00);
    chk("mr_fe",    stall_fe, 1);
    rst_n = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
